// File: rtl/ivd_pkg.sv
// ivd_pkg: shared definitions for the IVD assay sequencer.
//   ivd_state_e      sequencer FSM states
//   IVD_*_DEF        default parameter values (channels, sample width, counter width)
//   ivd_chw()        channel-index width, never below 1 bit
package ivd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MIX,
        ST_DETECT,
        ST_REPORT
    } ivd_state_e;

    localparam int unsigned IVD_NUM_CH_DEF = 9;
    localparam int unsigned IVD_DW_DEF     = 12;
    localparam int unsigned IVD_CW_DEF     = 16;

    function automatic int unsigned ivd_chw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ivd_assay_sequencer_if.sv
// ivd_assay_sequencer_if: result handshake between the sequencer and its consumer.
//   res_valid  result available (held until accepted)
//   res_ready  consumer accepts the result
//   res_ch     channel index of the result
//   res_data   captured detector sample
//   res_pos    positive call flag
// Modports: master (sequencer side), slave (consumer side).
interface ivd_assay_sequencer_if
    import ivd_pkg::*;
#(
    parameter int unsigned NUM_CH = IVD_NUM_CH_DEF,
    parameter int unsigned DW     = IVD_DW_DEF
);
    localparam int unsigned CHW = ivd_chw(NUM_CH);

    logic           res_valid;
    logic           res_ready;
    logic [CHW-1:0] res_ch;
    logic [DW-1:0]  res_data;
    logic           res_pos;

    modport master (
        output res_valid,
        output res_ch,
        output res_data,
        output res_pos,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_ch,
        input  res_data,
        input  res_pos,
        output res_ready
    );

endinterface

// File: rtl/ivd_phase_timer.sv
// ivd_phase_timer: loadable down-counter that flags the last cycle of a phase.
//   clk, rst   clock, synchronous active-high reset
//   load_i     load value_i (zero is treated as one)
//   value_i    phase duration in cycles
//   expire_o   high during the final cycle of the loaded duration
module ivd_phase_timer
    import ivd_pkg::*;
#(
    parameter int unsigned CW = IVD_CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= (value_i == '0) ? CW'(1) : value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // The count equals 1 during the last cycle of the phase.
    assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/ivd_assay_sequencer.sv
// ivd_assay_sequencer: runs fill / mix / detect / report for each enabled
// channel of a microfluidic assay, lowest channel first.
//   clk, rst                  clock, synchronous active-high reset
//   start, ch_mask            begin a run over the masked channels (IDLE only)
//   abort                     drop the run immediately, no done pulse
//   load_cycles, mix_cycles   fill / mix durations (0 treated as 1), latched at start
//   threshold                 positive-call threshold
//   inlet_open                valve pair per channel (bits 2i, 2i+1)
//   mix_en, det_sel           mixer enable, one-hot detector routing
//   det_valid, det_data       detector sample strobe and value
//   busy, done                run in progress, one-cycle end-of-run pulse
//   res                       result handshake (ivd_assay_sequencer_if.master)
// Optional feature: define IVD_THRESHOLD_EN to compute res_pos as
// (det_data >= threshold) at capture; otherwise res_pos is constant 0.
module ivd_assay_sequencer
    import ivd_pkg::*;
#(
    parameter int unsigned NUM_CH = IVD_NUM_CH_DEF,
    parameter int unsigned DW     = IVD_DW_DEF,
    parameter int unsigned CW     = IVD_CW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [CW-1:0]         load_cycles,
    input  logic [CW-1:0]         mix_cycles,
    input  logic [DW-1:0]         threshold,
    output logic [2*NUM_CH-1:0]   inlet_open,
    output logic [NUM_CH-1:0]     mix_en,
    output logic [NUM_CH-1:0]     det_sel,
    input  logic                  det_valid,
    input  logic [DW-1:0]         det_data,
    output logic                  busy,
    output logic                  done,
    ivd_assay_sequencer_if.master res
);

    localparam int unsigned CHW = ivd_chw(NUM_CH);

    ivd_state_e           state_q, state_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [CW-1:0]        load_q, load_d;
    logic [CW-1:0]        mix_q, mix_d;
    logic [2*NUM_CH-1:0]  inlet_q, inlet_d;
    logic [NUM_CH-1:0]    mix_en_q, mix_en_d;
    logic [NUM_CH-1:0]    det_sel_q, det_sel_d;
    logic                 done_q, done_d;
    logic                 res_valid_q, res_valid_d;
    logic [CHW-1:0]       res_ch_q, res_ch_d;
    logic [DW-1:0]        res_data_q, res_data_d;
    logic                 res_pos_q, res_pos_d;
    logic                 pos_call;

    logic                 tmr_load;
    logic [CW-1:0]        tmr_val;
    logic                 tmr_expire;

    // {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [CHW:0] find_from(input logic [NUM_CH-1:0] m,
                                               input int unsigned     from);
        logic [CHW:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i >= from && m[i] && !r[CHW]) begin
                r = {1'b1, CHW'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CHW-1:0] c);
        return NUM_CH'(1) << c;
    endfunction

    function automatic logic [2*NUM_CH-1:0] ch_pair(input logic [CHW-1:0] c);
        return (2*NUM_CH)'(3) << {c, 1'b0};
    endfunction

`ifdef IVD_THRESHOLD_EN
    assign pos_call = (det_data >= threshold);
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign pos_call = 1'b0;
`endif

    // One timer serves both LOAD and MIX: it is reloaded on entry to each phase.
    ivd_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .value_i  (tmr_val),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            mask_q      <= '0;
            load_q      <= '0;
            mix_q       <= '0;
            inlet_q     <= '0;
            mix_en_q    <= '0;
            det_sel_q   <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            res_pos_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            load_q      <= load_d;
            mix_q       <= mix_d;
            inlet_q     <= inlet_d;
            mix_en_q    <= mix_en_d;
            det_sel_q   <= det_sel_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            res_pos_q   <= res_pos_d;
        end
    end

    // Outputs are computed for the cycle after the edge, so each branch sets
    // the drive of the state being entered (or stayed in).
    always_comb begin
        logic [CHW:0] first;
        logic [CHW:0] nxt;

        first       = find_from(ch_mask, 0);
        nxt         = find_from(mask_q, 32'(ch_q) + 32'd1);

        state_d     = state_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        load_d      = load_q;
        mix_d       = mix_q;
        inlet_d     = '0;
        mix_en_d    = '0;
        det_sel_d   = '0;
        done_d      = 1'b0;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        res_pos_d   = res_pos_q;
        tmr_load    = 1'b0;
        tmr_val     = load_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first[CHW]) begin
                        mask_d   = ch_mask;
                        load_d   = load_cycles;
                        mix_d    = mix_cycles;
                        ch_d     = first[CHW-1:0];
                        inlet_d  = ch_pair(first[CHW-1:0]);
                        tmr_load = 1'b1;
                        tmr_val  = load_cycles;
                        state_d  = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (tmr_expire) begin
                    mix_en_d = ch_onehot(ch_q);
                    tmr_load = 1'b1;
                    tmr_val  = mix_q;
                    state_d  = ST_MIX;
                end else begin
                    inlet_d = ch_pair(ch_q);
                end
            end
            ST_MIX: begin
                if (tmr_expire) begin
                    det_sel_d = ch_onehot(ch_q);
                    state_d   = ST_DETECT;
                end else begin
                    mix_en_d = ch_onehot(ch_q);
                end
            end
            ST_DETECT: begin
                if (det_valid) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    res_data_d  = det_data;
                    res_pos_d   = pos_call;
                    state_d     = ST_REPORT;
                end else begin
                    det_sel_d = ch_onehot(ch_q);
                end
            end
            ST_REPORT: begin
                if (res.res_ready) begin
                    if (nxt[CHW]) begin
                        ch_d     = nxt[CHW-1:0];
                        inlet_d  = ch_pair(nxt[CHW-1:0]);
                        tmr_load = 1'b1;
                        tmr_val  = load_q;
                        state_d  = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition above, including a simultaneous
        // handshake or detector strobe.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            inlet_d     = '0;
            mix_en_d    = '0;
            det_sel_d   = '0;
            done_d      = 1'b0;
            res_valid_d = 1'b0;
            tmr_load    = 1'b0;
        end
    end

    assign inlet_open    = inlet_q;
    assign mix_en        = mix_en_q;
    assign det_sel       = det_sel_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign res.res_valid = res_valid_q;
    assign res.res_ch    = res_ch_q;
    assign res.res_data  = res_data_q;
    assign res.res_pos   = res_pos_q;

endmodule

// File: doc/ivd_assay_sequencer.md
IVD_ASSAY_SEQUENCER -- requirements
Module: ivd_assay_sequencer

Interface
REQ-001 Parameter NUM_CH, default 9: number of mixer/detector assay channels.
REQ-002 Parameter DW, default 12: detector sample width in bits.
REQ-003 Parameter CW, default 16: phase-duration counter width in bits.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: begin a run; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the run immediately.
REQ-008 Port ch_mask, input, NUM_CH: channels to run; bit i enables channel i.
REQ-009 Port load_cycles, input, CW: duration of the inlet-fill phase.
REQ-010 Port mix_cycles, input, CW: duration of the mixing phase.
REQ-011 Port threshold, input, DW: positive-call threshold; ignored without IVD_THRESHOLD_EN.
REQ-012 Port inlet_open, output, 2*NUM_CH: valve drives; bits 2i and 2i+1 are inlets a and b of channel i.
REQ-013 Port mix_en, output, NUM_CH: mixer pump enables.
REQ-014 Port det_sel, output, NUM_CH: one-hot routing of a mixer output to the shared detector.
REQ-015 Port det_valid, input, 1: detector sample strobe.
REQ-016 Port det_data, input, DW: detector sample.
REQ-017 Port busy, output, 1; Port done, output, 1 (single-cycle pulse).
REQ-018 Port res_valid, output, 1; Port res_ready, input, 1; Port res_ch, output, $clog2(NUM_CH); Port res_data, output, DW; Port res_pos, output, 1.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, MIX, DETECT, REPORT; busy SHALL be 1 in every state except IDLE.
REQ-020 In IDLE, start=1 with nonzero ch_mask SHALL latch ch_mask, load_cycles and mix_cycles, select the lowest set channel, and enter LOAD.
REQ-021 In IDLE, start=1 with ch_mask=0 SHALL pulse done for one cycle and remain in IDLE.
REQ-022 If start is sampled at edge k, both inlet_open bits of the selected channel SHALL be high in exactly cycles k+1 through k+L, where L is the latched load_cycles and L=0 is treated as 1.
REQ-023 mix_en[ch] SHALL be high for exactly M cycles immediately after LOAD, where M is the latched mix_cycles and M=0 is treated as 1.
REQ-024 In DETECT, det_sel[ch] SHALL be high until det_valid=1; det_data SHALL be captured on that edge and the FSM SHALL enter REPORT; det_valid outside DETECT SHALL be ignored.
REQ-025 In REPORT, res_valid SHALL be 1, and res_ch, res_data and res_pos SHALL be held stable until res_ready=1.
REQ-026 On the REPORT handshake, the FSM SHALL go to LOAD for the next set mask bit above ch; if no higher bit is set, it SHALL pulse done for one cycle and return to IDLE.
REQ-027 At most one channel SHALL have any of inlet_open, mix_en or det_sel asserted in any cycle; all of these outputs SHALL be registered.
REQ-028 abort=1 in any busy state SHALL return the FSM to IDLE on the next edge, with all valves, mixers and det_sel deasserted, res_valid=0 and no done pulse; abort has priority over a simultaneous res_ready or det_valid.
REQ-029 start while busy SHALL be ignored; changes to ch_mask or the cycle inputs mid-run SHALL have no effect.

Reset
REQ-030 rst SHALL force the FSM to IDLE and drive inlet_open, mix_en, det_sel, busy, done, res_valid, res_ch, res_data and res_pos to 0; reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-031 With macro IVD_THRESHOLD_EN defined, res_pos SHALL be registered as (captured det_data >= threshold) at capture.
REQ-032 Without IVD_THRESHOLD_EN, res_pos SHALL be constant 0 and no comparator SHALL be synthesised.

Structure
REQ-033 Package ivd_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-034 One sub-module, ivd_phase_timer (load/count-down/expire, zero treated as one), SHALL be instantiated for both the LOAD and MIX durations.

Verification
REQ-035 Mask 9'b000000101, L=3, M=4: inlet_open=0x3 for 3 cycles, mix_en[0] for 4 cycles, det_sel=1; det_valid with data 0x123 -> res_ch=0, res_data=0x123; channel 2 then runs; done pulses once.
REQ-036 Mask 0 with start -> done pulses 1 cycle; busy stays 0; no valve ever opens.
REQ-037 res_ready held 0 for 10 cycles in REPORT -> res_valid and res_data stable; no next LOAD until the handshake.
REQ-038 abort asserted in cycle 2 of MIX -> all outputs 0 on the next cycle, IDLE, no done; a following start runs normally.
REQ-039 L=0, M=0 -> each phase lasts exactly 1 cycle.
REQ-040 IVD_THRESHOLD_EN with threshold=0x100: data 0x100 -> res_pos=1, data 0x0FF -> res_pos=0; without the macro, res_pos=0 always.
